// File: rtl/control_sequencer.sv
// control_sequencer
//   Micro-step sequencer for the 8-bit bus CPU. Walks each instruction through
//   fetch (T0, T1) and execute (T2..T4) and drives the active-low strobes of
//   the PC, MAR, RAM, IR, A, B, ALU, flags and OUT blocks.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_run               1: advance one step per clock, 0: freeze, strobes high
//   i_opcode            IR[7:4], valid from T2 onward
//   i_carry, i_zero     registered ALU flags, sampled by JC/JZ in T2
//   i_pc_overflow       sticky PC carry-out, checked in T0
//   o_*n / o_*_din/den  active-low strobes (see decode below)
//   o_step              current micro-step 0..4
//   o_halted, o_fault   HALT state; fault = halt caused by PC overflow
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | executing; step register selects T0..T4
// ST_HALT | stopped by HLT or PC overflow; only i_rst leaves it
module control_sequencer #(
    parameter bit HALT_ON_PC_OVF = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [3:0] i_opcode,
    input  logic       i_carry,
    input  logic       i_zero,
    input  logic       i_pc_overflow,
    output logic       o_pc_cntn,
    output logic       o_pc_den,
    output logic       o_pc_din,
    output logic       o_mar_din,
    output logic       o_ram_den,
    output logic       o_ram_din,
    output logic       o_ir_din,
    output logic       o_ir_den,
    output logic       o_a_din,
    output logic       o_a_den,
    output logic       o_b_din,
    output logic       o_alu_den,
    output logic       o_alu_subn,
    output logic       o_flags_din,
    output logic       o_out_din,
    output logic [2:0] o_step,
    output logic       o_halted,
    output logic       o_fault
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state, state_nxt;
    logic [2:0] step, step_nxt;
    logic       fault, fault_nxt;

    // Active-high internal strobes; inverted onto the ports.
    logic pc_cnt, pc_den, pc_din, mar_din, ram_den, ram_din, ir_din, ir_den;
    logic a_din, a_den, b_din, alu_den, alu_sub, flags_din, out_din;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_RUN;
            step  <= 3'd0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            fault <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        fault_nxt = fault;
        pc_cnt    = 1'b0;
        pc_den    = 1'b0;
        pc_din    = 1'b0;
        mar_din   = 1'b0;
        ram_den   = 1'b0;
        ram_din   = 1'b0;
        ir_din    = 1'b0;
        ir_den    = 1'b0;
        a_din     = 1'b0;
        a_den     = 1'b0;
        b_din     = 1'b0;
        alu_den   = 1'b0;
        alu_sub   = 1'b0;
        flags_din = 1'b0;
        out_din   = 1'b0;

        // Reset and i_run=0 both freeze the step and keep every strobe idle.
        if (state == ST_RUN && i_run && !i_rst) begin
            case (step)
                3'd0: begin
                    if (HALT_ON_PC_OVF && i_pc_overflow) begin
                        state_nxt = ST_HALT;
                        step_nxt  = 3'd0;
                        fault_nxt = 1'b1;
                    end else begin
                        pc_den   = 1'b1;
                        mar_din  = 1'b1;
                        step_nxt = 3'd1;
                    end
                end
                3'd1: begin
                    ram_den  = 1'b1;
                    ir_din   = 1'b1;
                    pc_cnt   = 1'b1;
                    step_nxt = 3'd2;
                end
                3'd2: begin
                    step_nxt = 3'd0;
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_den   = 1'b1;
                            mar_din  = 1'b1;
                            step_nxt = 3'd3;
                        end
                        OP_LDI: begin
                            ir_den = 1'b1;
                            a_din  = 1'b1;
                        end
                        OP_JMP: begin
                            ir_den = 1'b1;
                            pc_din = 1'b1;
                        end
                        OP_JC: begin
                            ir_den = i_carry;
                            pc_din = i_carry;
                        end
                        OP_JZ: begin
                            ir_den = i_zero;
                            pc_din = i_zero;
                        end
                        OP_OUT: begin
                            a_den   = 1'b1;
                            out_din = 1'b1;
                        end
                        OP_HLT: begin
                            state_nxt = ST_HALT;
                            fault_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    step_nxt = 3'd0;
                    case (i_opcode)
                        OP_LDA: begin
                            ram_den = 1'b1;
                            a_din   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_den  = 1'b1;
                            b_din    = 1'b1;
                            step_nxt = 3'd4;
                        end
                        OP_STA: begin
                            a_den   = 1'b1;
                            ram_din = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    step_nxt = 3'd0;
                    if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                        alu_den   = 1'b1;
                        a_din     = 1'b1;
                        flags_din = 1'b1;
                        alu_sub   = (i_opcode == OP_SUB);
                    end
                end
                default: step_nxt = 3'd0;
            endcase
        end
    end

    assign o_pc_cntn   = ~pc_cnt;
    assign o_pc_den    = ~pc_den;
    assign o_pc_din    = ~pc_din;
    assign o_mar_din   = ~mar_din;
    assign o_ram_den   = ~ram_den;
    assign o_ram_din   = ~ram_din;
    assign o_ir_din    = ~ir_din;
    assign o_ir_den    = ~ir_den;
    assign o_a_din     = ~a_din;
    assign o_a_den     = ~a_den;
    assign o_b_din     = ~b_din;
    assign o_alu_den   = ~alu_den;
    assign o_alu_subn  = ~alu_sub;
    assign o_flags_din = ~flags_din;
    assign o_out_din   = ~out_din;
    assign o_step      = step;
    assign o_halted    = (state == ST_HALT);
    assign o_fault     = fault;

endmodule
